seg7_scan_ctrl: RTL

Time-multiplexing scan controller for the board's 8-digit, common-anode seven-segment display. It holds a 32-bit hex value in a double-buffered register and walks the eight anodes in sequence, digit 0 first. Each digit's nibble is decoded to active-low cathodes, and the controller inserts an all-off blanking gap between digits to suppress ghosting. It sits between the system's register/write logic and the display pins.

---
 rtl/seg7_pkg.sv | 25 ++
 rtl/hex_to_seg7.sv | 11 +
 rtl/seg7_scan_ctrl.sv | 137 +++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared types and constants for the seven-segment scan controller.
// The font is a..g packed MSB-first and active-low, matching the cathode wiring.
package seg7_pkg;

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } state_t;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [7:0] AN_OFF  = 8'hFF;

    localparam logic [6:0] FONT [16] = '{
        7'h01, 7'h4F, 7'h12, 7'h06,
        7'h4C, 7'h24, 7'h20, 7'h0F,
        7'h00, 7'h04, 7'h08, 7'h60,
        7'h31, 7'h42, 7'h30, 7'h38
    };

    // Active-low anode pattern that lights only digit k.
    function automatic logic [7:0] an_select(input logic [2:0] k);
        return ~(8'd1 << k);
    endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment decoder.
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = FONT[nibble];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Eight-digit common-anode scan controller with blanking gaps and a
// double-buffered display value that is swapped only at frame end.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int DIGIT_CYCLES = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_en,
    input  logic [31:0] wr_data,
    input  logic [7:0]  digit_en,
    output logic [6:0]  seg,
    output logic [7:0]  an,
    output logic        frame_done,
    output logic        pending
);

    localparam int     MAX_DB     = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
    localparam int     CNT_RANGE  = (MAX_DB > 2) ? MAX_DB : 2;
    localparam int     CW         = $clog2(CNT_RANGE);
    localparam bit     HAS_BLANK  = (BLANK_CYCLES > 0);
    localparam state_t RST_STATE  = HAS_BLANK ? BLANK : SHOW;
    localparam logic [CW-1:0] DIGIT_LAST = CW'(DIGIT_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(HAS_BLANK ? BLANK_CYCLES - 1 : 0);

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [2:0]    idx, idx_nxt;
    logic          frame_end;

    logic [31:0]   shadow, active;
    logic [3:0]    nibble;
    logic [6:0]    font_seg;
    logic [7:0]    an_nxt;
    logic [6:0]    seg_nxt;

    // Slot sequencing: state, in-slot counter and digit index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RST_STATE;
            cnt   <= '0;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            idx   <= idx_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + 1'b1;
        idx_nxt   = idx;
        frame_end = 1'b0;
        unique case (state)
            BLANK: begin
                if (cnt == BLANK_LAST) begin
                    state_nxt = SHOW;
                    cnt_nxt   = '0;
                end
            end
            SHOW: begin
                if (cnt == DIGIT_LAST) begin
                    cnt_nxt   = '0;
                    idx_nxt   = idx + 3'd1;
                    frame_end = (idx == 3'd7);
                    state_nxt = HAS_BLANK ? BLANK : SHOW;
                end
            end
        endcase
    end

    // A write coinciding with frame end still wins the shadow; active takes the older shadow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow     <= '0;
            active     <= '0;
            pending    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= frame_end;
            if (frame_end && pending) begin
                active <= shadow;
            end
            if (wr_en) begin
                shadow  <= wr_data;
                pending <= 1'b1;
            end else if (frame_end) begin
                pending <= 1'b0;
            end
        end
    end

    always_comb begin
        nibble = active[3:0];
        unique case (idx)
            3'd0: nibble = active[3:0];
            3'd1: nibble = active[7:4];
            3'd2: nibble = active[11:8];
            3'd3: nibble = active[15:12];
            3'd4: nibble = active[19:16];
            3'd5: nibble = active[23:20];
            3'd6: nibble = active[27:24];
            3'd7: nibble = active[31:28];
        endcase
    end

    hex_to_seg7 u_font (
        .nibble (nibble),
        .seg    (font_seg)
    );

    always_comb begin
        an_nxt  = AN_OFF;
        seg_nxt = SEG_OFF;
        if (state == SHOW) begin
            seg_nxt = font_seg;
            if (digit_en[idx]) begin
                an_nxt = an_select(idx);
            end
        end
    end

    // Output pins are registered so anodes and cathodes switch on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an  <= AN_OFF;
            seg <= SEG_OFF;
        end else begin
            an  <= an_nxt;
            seg <= seg_nxt;
        end
    end

endmodule
